bram_arbiter: RTL

Two-port access controller that shares the single-ported-write, registered-read `bram` between the instruction-fetch (imem) and load/store (dmem) memory interfaces of the core. It accepts valid/ready requests from both sides, arbitrates, and converts byte addresses to BRAM word addresses. It drives the BRAM write/read strobes and returns read data one cycle after issue. It sits between the core's memory ports and the `bram` instance in the FPGA top level.

---
 rtl/bram_arbiter_pkg.sv | 7 +
 rtl/bram_arb_grant.sv | 29 ++
 rtl/bram_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// rtl/bram_arbiter_pkg.sv - shared BRAM geometry and arbiter enums
package configure;
  localparam int bram_depth = 10;

  typedef enum logic {IDLE, BUSY} bram_arb_state_t;
  typedef enum logic {PORT_IMEM, PORT_DMEM} bram_arb_port_t;
endpackage

// File: rtl/bram_arb_grant.sv
// rtl/bram_arb_grant.sv - combinational grant picker; BRAM_ARB_RR_EN selects round-robin
module bram_arb_grant
  import configure::*;
(
  input  logic           imem_valid,
  input  logic           dmem_valid,
`ifdef BRAM_ARB_RR_EN
  input  bram_arb_port_t ptr,
`endif
  output bram_arb_port_t grant
);

  bram_arb_port_t pref;

`ifdef BRAM_ARB_RR_EN
  assign pref = ptr;
`else
  assign pref = PORT_DMEM;
`endif

  always_comb begin
    grant = PORT_DMEM;
    if (imem_valid && dmem_valid)
      grant = pref;
    else if (imem_valid)
      grant = PORT_IMEM;
  end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - shares one BRAM between imem and dmem; BRAM_ARB_RR_EN enables round-robin
module bram_arbiter
  import configure::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_valid,
  input  logic                  imem_instr,
  input  logic [31:0]           imem_addr,
  input  logic [31:0]           imem_wdata,
  input  logic [3:0]            imem_wstrb,
  output logic                  imem_ready,
  output logic [31:0]           imem_rdata,
  input  logic                  dmem_valid,
  input  logic                  dmem_instr,
  input  logic [31:0]           dmem_addr,
  input  logic [31:0]           dmem_wdata,
  input  logic [3:0]            dmem_wstrb,
  output logic                  dmem_ready,
  output logic [31:0]           dmem_rdata,
  output logic                  bram_wen,
  output logic [bram_depth-1:0] bram_waddr,
  output logic [bram_depth-1:0] bram_raddr,
  output logic [31:0]           bram_wdata,
  output logic [3:0]            bram_wstrb,
  input  logic [31:0]           bram_rdata
);

  bram_arb_state_t state;
  bram_arb_port_t  grant;
  bram_arb_port_t  grant_q;
  logic            any_valid;
  logic            issue;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_wstrb;

  // instr flags and the byte-offset/wrapped address bits have no effect on the BRAM access
  logic unused_bits;
  assign unused_bits = ^{imem_instr, dmem_instr,
                         imem_addr[31:bram_depth+2], imem_addr[1:0],
                         dmem_addr[31:bram_depth+2], dmem_addr[1:0]};

`ifdef BRAM_ARB_RR_EN
  bram_arb_port_t rr_ptr;

  bram_arb_grant u_grant (
    .imem_valid (imem_valid),
    .dmem_valid (dmem_valid),
    .ptr        (rr_ptr),
    .grant      (grant)
  );
`else
  bram_arb_grant u_grant (
    .imem_valid (imem_valid),
    .dmem_valid (dmem_valid),
    .grant      (grant)
  );
`endif

  assign any_valid = imem_valid || dmem_valid;
  assign issue     = reset && (state == IDLE) && any_valid;

  assign sel_addr  = (grant == PORT_DMEM) ? dmem_addr  : imem_addr;
  assign sel_wdata = (grant == PORT_DMEM) ? dmem_wdata : imem_wdata;
  assign sel_wstrb = (grant == PORT_DMEM) ? dmem_wstrb : imem_wstrb;

  always_comb begin
    bram_wen   = 1'b0;
    bram_waddr = '0;
    bram_raddr = '0;
    bram_wdata = '0;
    bram_wstrb = '0;
    if (issue) begin
      bram_wen   = (sel_wstrb != 4'b0000);
      bram_waddr = sel_addr[bram_depth+1:2];
      bram_raddr = sel_addr[bram_depth+1:2];
      bram_wdata = sel_wdata;
      bram_wstrb = sel_wstrb;
    end
  end

  // reset gates the response so a reset landing in BUSY drops the pending ready
  assign imem_ready = reset && (state == BUSY) && (grant_q == PORT_IMEM);
  assign dmem_ready = reset && (state == BUSY) && (grant_q == PORT_DMEM);
  assign imem_rdata = imem_ready ? bram_rdata : 32'h0;
  assign dmem_rdata = dmem_ready ? bram_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      grant_q <= PORT_IMEM;
`ifdef BRAM_ARB_RR_EN
      rr_ptr  <= PORT_DMEM;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_q <= grant;
            state   <= BUSY;
`ifdef BRAM_ARB_RR_EN
            rr_ptr  <= (grant == PORT_DMEM) ? PORT_IMEM : PORT_DMEM;
`endif
          end
        end
        BUSY:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
